// File: rtl/vga_timing_gen.sv
// VGA raster timing source: position counters, registered sync/active/coordinate outputs.
// Optional 16-bit frame counter port enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_reset_n,
  output logic [15:0] o_horz_coord,
  output logic [15:0] o_vert_coord,
  output logic        o_in_active_area,
  output logic        o_horz_sync,
  output logic        o_vert_sync,
  output logic        o_line_start,
  output logic        o_frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0] o_frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
  localparam logic [15:0] HS_FIRST   = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] HS_LAST    = 16'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST   = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] VS_LAST    = 16'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [15:0] h_q, h_d;
  logic [15:0] v_q, v_d;
  logic [15:0] horz_coord_q, horz_coord_d;
  logic [15:0] vert_coord_q, vert_coord_d;
  logic        active_q, active_d;
  logic        horz_sync_q, horz_sync_d;
  logic        vert_sync_q, vert_sync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        run;
  logic        hs_on, vs_on;

  // Counters only move once the released reset has crossed the two-flop synchroniser.
  assign run = rst_sync_q[1];

  always_comb begin
    rst_sync_d    = {rst_sync_q[0], 1'b1};
    h_d           = h_q;
    v_d           = v_q;
    horz_coord_d  = 16'd0;
    vert_coord_d  = 16'd0;
    active_d      = 1'b0;
    hs_on         = 1'b0;
    vs_on         = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (run) begin
      if (h_q == H_LAST) begin
        h_d = 16'd0;
        v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end

      // Outputs describe the position the counters will hold after this edge.
      active_d      = (h_d < H_ACT) && (v_d < V_ACT);
      horz_coord_d  = active_d ? h_d : 16'd0;
      vert_coord_d  = active_d ? v_d : 16'd0;
      hs_on         = (h_d >= HS_FIRST) && (h_d <= HS_LAST);
      vs_on         = (v_d >= VS_FIRST) && (v_d <= VS_LAST);
      line_start_d  = (h_d == 16'd0);
      frame_start_d = (h_d == 16'd0) && (v_d == 16'd0);
    end

    horz_sync_d = hs_on ? H_SYNC_POL : ~H_SYNC_POL;
    vert_sync_d = vs_on ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync_q    <= 2'b00;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      horz_coord_q  <= 16'd0;
      vert_coord_q  <= 16'd0;
      active_q      <= 1'b0;
      horz_sync_q   <= ~H_SYNC_POL;
      vert_sync_q   <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      h_q           <= h_d;
      v_q           <= v_d;
      horz_coord_q  <= horz_coord_d;
      vert_coord_q  <= vert_coord_d;
      active_q      <= active_d;
      horz_sync_q   <= horz_sync_d;
      vert_sync_q   <= vert_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_horz_coord     = horz_coord_q;
  assign o_vert_coord     = vert_coord_q;
  assign o_in_active_area = active_q;
  assign o_horz_sync      = horz_sync_q;
  assign o_vert_sync      = vert_sync_q;
  assign o_line_start     = line_start_q;
  assign o_frame_start    = frame_start_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic        started_q, started_d;

  // The reset position is also (H_LAST, V_LAST); started_q keeps that first entry uncounted.
  always_comb begin
    started_d     = started_q | run;
    frame_count_d = frame_count_q;
    if (run && started_q && (h_q == H_LAST) && (v_q == V_LAST)) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      started_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      started_q     <= started_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised reset/run segments on a default-timing and a small active-high-sync instance,
// checked every cycle against a position model computed from elapsed cycle count.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst_n;

  logic [15:0] a_x, a_y, b_x, b_y;
  logic        a_act, a_hs, a_vs, a_ls, a_fs;
  logic        b_act, b_hs, b_vs, b_ls, b_fs;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut_a (
    .i_pix_clk        (clk),
    .i_reset_n        (rst_n),
    .o_horz_coord     (a_x),
    .o_vert_coord     (a_y),
    .o_in_active_area (a_act),
    .o_horz_sync      (a_hs),
    .o_vert_sync      (a_vs),
    .o_line_start     (a_ls),
    .o_frame_start    (a_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    .o_frame_count    (a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (
    .i_pix_clk        (clk),
    .i_reset_n        (rst_n),
    .o_horz_coord     (b_x),
    .o_vert_coord     (b_y),
    .o_in_active_area (b_act),
    .o_horz_sync      (b_hs),
    .o_vert_sync      (b_vs),
    .o_line_start     (b_ls),
    .o_frame_start    (b_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    .o_frame_count    (b_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  // Expected outputs t cycles after the first counting edge (t = 0 is position (0,0)).
  function automatic exp_t ref_pos(input int t, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input bit hp, input bit vp, input bit idle);
    exp_t e;
    int htot, vtot, h, v;
    htot = ha + hf + hsw + hb;
    vtot = va + vf + vsw + vb;
    e.x = 0; e.y = 0; e.act = 0; e.ls = 0; e.fs = 0; e.fc = 0;
    e.hs = !hp;
    e.vs = !vp;
    if (!idle) begin
      h = t % htot;
      v = (t / htot) % vtot;
      e.act = (h < ha) && (v < va);
      e.x   = e.act ? h : 0;
      e.y   = e.act ? v : 0;
      e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
      e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      e.fc  = (t / (htot * vtot)) % 65536;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit idle, input int t);
    exp_t ea, eb;
    ea = ref_pos(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, idle);
    eb = ref_pos(t, 8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1, idle);
    check("a_x",   32'(a_x),   32'(ea.x));
    check("a_y",   32'(a_y),   32'(ea.y));
    check("a_act", 32'(a_act), 32'(ea.act));
    check("a_hs",  32'(a_hs),  32'(ea.hs));
    check("a_vs",  32'(a_vs),  32'(ea.vs));
    check("a_ls",  32'(a_ls),  32'(ea.ls));
    check("a_fs",  32'(a_fs),  32'(ea.fs));
    check("b_x",   32'(b_x),   32'(eb.x));
    check("b_y",   32'(b_y),   32'(eb.y));
    check("b_act", 32'(b_act), 32'(eb.act));
    check("b_hs",  32'(b_hs),  32'(eb.hs));
    check("b_vs",  32'(b_vs),  32'(eb.vs));
    check("b_ls",  32'(b_ls),  32'(eb.ls));
    check("b_fs",  32'(b_fs),  32'(eb.fs));
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("a_fc",  32'(a_fc),  32'(ea.fc));
    check("b_fc",  32'(b_fc),  32'(eb.fc));
`endif
  endtask

  // Release reset, find the first counting edge, then check ncycles positions.
  task automatic run_segment(input int seg, input int ncycles);
    int k;
    bit found;
    int last_ls, hs_cnt, last_fs_b, last_ls_b, vs_cnt_b;
    rst_n = 1'b1;
    found = 1'b0;
    for (k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (a_fs) begin
        found = 1'b1;
        break;
      end
      check_outputs(1'b1, 0);
    end
    check("start_seen", 32'(found), 32'd1);
    if (!found) return;
    check("start_latency", 32'((k >= 2) && (k <= 3)), 32'd1);

    last_ls = -1; hs_cnt = 0; last_fs_b = -1; last_ls_b = -1; vs_cnt_b = 0;
    for (int t = 0; t < ncycles; t++) begin
      if (t > 0) @(negedge clk);
      check_outputs(1'b0, t);
      if (a_ls) begin
        if (last_ls >= 0) begin
          check("a_line_period", 32'(t - last_ls), 32'd800);
          check("a_hsync_width", 32'(hs_cnt), 32'd96);
        end
        last_ls = t;
        hs_cnt  = 0;
      end
      if (!a_hs) hs_cnt++;
      if (b_ls) begin
        if (last_ls_b >= 0) check("b_line_period", 32'(t - last_ls_b), 32'd15);
        last_ls_b = t;
      end
      if (b_fs) begin
        if (last_fs_b >= 0) begin
          check("b_frame_period", 32'(t - last_fs_b), 32'd105);
          check("b_vsync_width", 32'(vs_cnt_b), 32'd15);
        end
        last_fs_b = t;
        vs_cnt_b  = 0;
      end
      if (b_vs) vs_cnt_b++;
    end
    $display("segment %0d: %0d cycles checked, latency %0d edges", seg, ncycles, k);
  endtask

  // Assert reset part-way through a clock period and expect idle outputs before any edge.
  task automatic async_reset();
    @(posedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check_outputs(1'b1, 0);
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check_outputs(1'b1, 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs(1'b1, 0);
    end
    check("a_idle_hsync", 32'(a_hs), 32'd1);
    check("a_idle_vsync", 32'(a_vs), 32'd1);

    // Stop at h=300 on line 2 of the default instance, then reset mid-line.
    run_segment(0, 2 * 800 + 300 + 1);
    async_reset();

    for (int s = 1; s <= 6; s++) begin
      run_segment(s, int'($urandom_range(50, 3000)));
      async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
